// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C register-file target.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_REG,
    S_WACK,       // ACK slot after a register-pointer or write-data byte
    S_WDATA,
    S_RDATA,
    S_RACK,
    S_IGNORE,
    S_WAIT_STOP
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Audio codec slot.
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h1A;
  localparam int         DEFAULT_FILTER_LEN = 3;

  // The general-call address (0x00) is never answered, even if configured.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] slave_addr);
    return (addr_byte[7:1] == slave_addr) && (addr_byte[7:1] != 7'h00);
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions one raw I2C pin: 2-FF sync, FILTER_LEN-sample glitch filter, edge strobes.
// Latency: 2+FILTER_LEN sys_clk cycles from pin change to level/rise/fall.
// Backpressure: none; strobes are single-cycle and cannot be held off.
//
// Ports:
//   clk, rst_n   - system clock, async active-low reset
//   pin          - raw pin level
//   level        - filtered level (resets to IDLE_LEVEL)
//   rise, fall   - one-cycle strobes coincident with a filtered level change
module i2c_line_filter #(
  parameter int   FILTER_LEN = 3,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int             CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;     // consecutive synced samples disagreeing with level

  // Sync and filter reset to the bus idle level so release from reset
  // never manufactures an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
      level <= IDLE_LEVEL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          rise  <= sync2;
          fall  <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C target with an 8-bit register pointer driving a simple synchronous register-file port.
// Latency: pin to bit event 2+FILTER_LEN cycles; wr_en fires on the SCL rise of the 8th data bit.
// Backpressure: none; no clock stretching, the register file must accept wr_en every pulse.
//
// Ports:
//   sys_clk, sys_rst_n  - system clock, async active-low reset
//   scl_in, sda_in      - raw bus levels
//   sda_oe              - 1 pulls SDA low (tristate buffer lives at the top level)
//   wr_en/wr_addr/wr_data - one-cycle register write
//   rd_addr/rd_data     - register pointer out, register contents back (<=1 cycle)
//   busy                - addressed transaction in progress
module i2c_reg_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
  parameter int         FILTER_LEN = DEFAULT_FILTER_LEN,
  parameter bit         AUTO_INC   = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN), .IDLE_LEVEL(1'b1)) u_scl_filter (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .pin   (scl_in),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN), .IDLE_LEVEL(1'b1)) u_sda_filter (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .pin   (sda_in),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  state_t     state;
  logic [3:0] bit_cnt;
  logic [7:0] sr;        // receive: shifts in LSB; transmit: sr[7] is the next bit to drive
  logic       rw;        // 1 = read transaction

  logic       start_cond;
  logic       stop_cond;
  logic [7:0] rx_byte;
  logic       last_bit;
  logic [7:0] ptr_inc;

  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;
  assign rx_byte    = {sr[6:0], sda_lvl};
  assign last_bit   = (bit_cnt == 4'd7);
  assign ptr_inc    = rd_addr + {7'd0, AUTO_INC};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      bit_cnt <= 4'd0;
      sr      <= 8'h00;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= 8'h00;
      wr_data <= 8'h00;
      rd_addr <= 8'h00;
      busy    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      // Bus conditions outrank bit handling; the pointer survives a
      // repeated start so a read returns the register just selected.
      if (start_cond) begin
        state   <= S_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else if (stop_cond) begin
        state   <= S_IDLE;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          S_ADDR: begin
            if (scl_rise) begin
              sr <= rx_byte;
              if (last_bit) begin
                bit_cnt <= 4'd0;
                if (addr_match(rx_byte, SLAVE_ADDR)) begin
                  state <= S_ADDR_ACK;
                  busy  <= 1'b1;
                  rw    <= rx_byte[0];
                end else begin
                  state <= S_IGNORE;
                  busy  <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          // bit_cnt 0: ACK not yet driven; 1: ACK on the bus.
          S_ADDR_ACK: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_oe  <= 1'b1;
                bit_cnt <= 4'd1;
              end else begin
                bit_cnt <= 4'd0;
                if (rw) begin
                  state  <= S_RDATA;
                  sr     <= {rd_data[6:0], 1'b0};
                  sda_oe <= ~rd_data[7];
                end else begin
                  state  <= S_REG;
                  sda_oe <= 1'b0;
                end
              end
            end
          end

          S_REG, S_WDATA: begin
            if (scl_rise) begin
              sr <= rx_byte;
              if (last_bit) begin
                bit_cnt <= 4'd0;
                state   <= S_WACK;
                if (state == S_REG) begin
                  rd_addr <= rx_byte;
                end else begin
                  wr_en   <= 1'b1;
                  wr_addr <= rd_addr;
                  wr_data <= rx_byte;
                  rd_addr <= ptr_inc;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          S_WACK: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_oe  <= 1'b1;
                bit_cnt <= 4'd1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= S_WDATA;
              end
            end
          end

          // bit_cnt counts SCL rises of the byte; the MSB went out on entry.
          S_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= S_RACK;
              end else begin
                sda_oe <= ~sr[7];
                sr     <= {sr[6:0], 1'b0};
              end
            end
          end

          // bit_cnt 1 marks a master ACK seen; the following fall starts the next byte.
          S_RACK: begin
            if (scl_rise) begin
              if (sda_lvl == I2C_ACK) begin
                rd_addr <= ptr_inc;
                bit_cnt <= 4'd1;
              end else begin
                state  <= S_WAIT_STOP;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
              end
            end else if (scl_fall && (bit_cnt == 4'd1)) begin
              bit_cnt <= 4'd0;
              sr      <= {rd_data[6:0], 1'b0};
              sda_oe  <= ~rd_data[7];
              state   <= S_RDATA;
            end
          end

          default: begin
            // S_IDLE, S_IGNORE, S_WAIT_STOP: only bus conditions matter.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master, register-write scoreboard, directed checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_reg_slave;
  import i2c_pkg::*;

  localparam int Q = 10;  // sys_clk cycles per quarter SCL period

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       scl_m     = 1'b1;
  logic       sda_m     = 1'b1;
  logic       scl_in, sda_in, sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

  int          checks    = 0;
  int          errors    = 0;
  int          oe_cycles = 0;
  logic [15:0] exp_wr[$];   // {addr, data} of expected register writes
  logic [7:0]  rbyte;

  always #5 sys_clk = ~sys_clk;

  // Open-drain bus: master and target both only pull low.
  assign scl_in  = scl_m;
  assign sda_in  = sda_m & ~sda_oe;
  assign rd_data = rd_addr ^ 8'h5A;

  i2c_reg_slave #(.SLAVE_ADDR(7'h1A), .FILTER_LEN(3), .AUTO_INC(1'b1)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every wr_en pops one expected write.
  always @(negedge sys_clk) begin
    logic [15:0] e;
    if (sda_oe) oe_cycles++;
    if (sys_rst_n && wr_en) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got %02h:%02h expected none", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr_data", 32'({wr_addr, wr_data}), 32'(e));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    sda_m = 1'b1; cyc(2*Q);
  endtask

  task automatic bit_out(input logic b);
    sda_m = b;    cyc(Q);
    scl_m = 1'b1; cyc(2*Q);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic bit_in(output logic b);
    sda_m = 1'b1; cyc(Q);
    scl_m = 1'b1; cyc(Q);
    b = sda_in;   cyc(Q);
    scl_m = 1'b0; cyc(Q);
  endtask

  task automatic send(input logic [7:0] v, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) bit_out(v[i]);
    bit_in(a);
    check(name, 32'(a), 32'(exp_ack));
  endtask

  task automatic recv(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      v[i] = b;
    end
  endtask

  initial begin
    logic [7:0] ab;
    ab = 8'h34;

    // Reset state
    cyc(3);
    check("rst_sda_oe",  32'(sda_oe),    32'h0);
    check("rst_wr_en",   32'(wr_en),     32'h0);
    check("rst_wr_addr", 32'(wr_addr),   32'h0);
    check("rst_wr_data", 32'(wr_data),   32'h0);
    check("rst_rd_addr", 32'(rd_addr),   32'h0);
    check("rst_busy",    32'(busy),      32'h0);
    check("rst_state",   32'(dut.state), 32'(S_IDLE));
    sys_rst_n = 1'b1;
    cyc(10);

    // Single register write
    exp_wr.push_back(16'h0712);
    i2c_start();
    send(8'h34, 1'b0, "wr_addr_ack");
    check("busy_set", 32'(busy), 32'h1);
    send(8'h07, 1'b0, "wr_reg_ack");
    send(8'h12, 1'b0, "wr_data_ack");
    i2c_stop();
    check("busy_after_stop", 32'(busy), 32'h0);
    check("ptr_after_wr", 32'(rd_addr), 32'h08);

    // Wrong address: no ACK, no drive, no busy
    oe_cycles = 0;
    i2c_start();
    send(8'h36, 1'b1, "wrong_addr_nack");
    send(8'h07, 1'b1, "wrong_reg_nack");
    check("busy_wrong", 32'(busy), 32'h0);
    i2c_stop();
    check("no_oe_wrong", 32'(oe_cycles), 32'h0);

    // Auto-increment across the 0xFF wrap
    exp_wr.push_back(16'hFEAA);
    exp_wr.push_back(16'hFFBB);
    exp_wr.push_back(16'h00CC);
    i2c_start();
    send(8'h34, 1'b0, "wrap_addr_ack");
    send(8'hFE, 1'b0, "wrap_reg_ack");
    send(8'hAA, 1'b0, "wrap_d0_ack");
    send(8'hBB, 1'b0, "wrap_d1_ack");
    send(8'hCC, 1'b0, "wrap_d2_ack");
    i2c_stop();
    check("wrap_writes_done", 32'(exp_wr.size()), 32'h0);

    // Repeated-start read, rd_data = addr ^ 0x5A
    i2c_start();
    send(8'h34, 1'b0, "rd_waddr_ack");
    send(8'h05, 1'b0, "rd_reg_ack");
    i2c_start();
    send(8'h35, 1'b0, "rd_raddr_ack");
    check("busy_read", 32'(busy), 32'h1);
    recv(rbyte);
    check("rd_byte0", 32'(rbyte), 32'h5F);
    bit_out(1'b0);
    recv(rbyte);
    check("rd_byte1", 32'(rbyte), 32'h5C);
    bit_out(1'b1);
    check("oe_after_nack",   32'(sda_oe),  32'h0);
    check("busy_after_nack", 32'(busy),    32'h0);
    check("ptr_after_read",  32'(rd_addr), 32'h06);
    check("state_wait_stop", 32'(dut.state), 32'(S_WAIT_STOP));
    i2c_stop();

    // STOP after 4 bits of a data byte
    i2c_start();
    send(8'h34, 1'b0, "abort_addr_ack");
    send(8'h10, 1'b0, "abort_reg_ack");
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
    i2c_stop();
    check("abort_state", 32'(dut.state), 32'(S_IDLE));
    check("abort_busy",  32'(busy),      32'h0);

    // Async reset while the address ACK is on the bus
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_out(ab[i]);
    check("ack_driven", 32'(sda_oe), 32'h1);
    scl_m = 1'b1;
    cyc(Q);
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("oe_async_rst",   32'(sda_oe), 32'h0);
    check("busy_async_rst", 32'(busy),   32'h0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    cyc(3);
    sys_rst_n = 1'b1;
    cyc(10);

    // 2-cycle SCL glitch with SDA rising under it
    i2c_start();
    send(8'h34, 1'b0, "glitch_addr_ack");
    sda_m = 1'b0; cyc(Q);
    scl_m = 1'b1; cyc(1);
    sda_m = 1'b1; cyc(1);
    scl_m = 1'b0; cyc(2*Q);
    check("glitch_state",   32'(dut.state),   32'(S_REG));
    check("glitch_bit_cnt", 32'(dut.bit_cnt), 32'h0);
    check("glitch_busy",    32'(busy),        32'h1);
    exp_wr.push_back(16'h2033);
    send(8'h20, 1'b0, "glitch_reg_ack");
    send(8'h33, 1'b0, "glitch_data_ack");
    i2c_stop();

    check("scoreboard_empty", 32'(exp_wr.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
